instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch front end sitting directly upstream of cpu_64bit decode. Generates sequential 64-bit fetch addresses and issues them to instruction memory over a valid/ready request channel. Collects in-order responses into a small prefetch FIFO and hands {pc, instruction} to decode over a valid/ready channel. Takes a redirect (branch/jump/trap target) that flushes in-flight and buffered work.

Parameters:
XLEN, 64, address/PC width
RESET_PC, 64'h0, fetch address after reset
FIFO_DEPTH, 4, prefetch entries; power of two, >= 2
ADDR_STEP, 4, PC increment per instruction (bytes)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset; asynchronous, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address, word aligned
imem_rsp_valid  input  1  response valid, in request order, latency >= 1 cycle
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  XLEN  new fetch target
if_valid  output  1  instruction available to decode
if_ready  input  1  decode accepts instruction
if_instr  output  32  instruction at FIFO head
if_pc  output  XLEN  PC of if_instr
pc_out  output  XLEN  current fetch PC (next address to request)

Behaviour:
- Reset (async assert): fetch_pc = resp_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0; imem_req_valid = 0, if_valid = 0, if_instr = 0, if_pc = RESET_PC, pc_out = RESET_PC. Reset mid-transaction: pending responses after deassert are NOT dropped; memory must be reset alongside.
- Credit rule: imem_req_valid = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH). FIFO can never overflow.
- imem_req_addr = fetch_pc. Request handshake (valid && ready): fetch_pc += ADDR_STEP, outstanding += 1. Address wraps modulo 2^XLEN, no flag.
- Response with drop_cnt == 0: push {resp_pc, imem_rsp_data}, resp_pc += ADDR_STEP, outstanding -= 1. Response with drop_cnt > 0: discarded, drop_cnt -= 1, outstanding -= 1.
- imem_rsp_valid with outstanding == 0 (protocol violation): ignored, no state change.
- Decode side: if_valid = FIFO non-empty; if_instr/if_pc = FIFO head, stable while if_valid && !if_ready. Pop on if_valid && if_ready. Push and pop same cycle: occupancy unchanged.
- Latency: first instruction reaches decode 1 cycle after its response (registered FIFO). Empty-FIFO bypass is not provided.
- Redirect (highest priority): in the redirect cycle no request issued, any pop and any push suppressed. Next edge: FIFO flushed, fetch_pc = resp_pc = {redirect_pc[XLEN-1:2], 2'b00}, drop_cnt = outstanding after counting down any response arriving in the redirect cycle (that response itself is discarded). Back-to-back redirects: last one wins; drop_cnt accumulates correctly.
- pc_out mirrors fetch_pc.

Optional Feature:
FETCH_PERF_EN: when defined, adds outputs perf_fetched (64, count of instructions popped to decode) and perf_stall (64, cycles with if_ready && !if_valid); both reset to 0, wrap at 2^64, not cleared by redirect. When undefined, ports and counters are absent; all other behaviour identical.

Test Plan:
- Reset then imem_req_ready=1, 1-cycle memory returning addr>>2: decode receives pc 0,4,8,12 with instr 0,1,2,3 in order; pc_out=16 after 4 requests.
- imem_req_ready=1, if_ready=0 held, FIFO_DEPTH=4: exactly 4 requests issued, imem_req_valid low thereafter, if_pc stays 0; release if_ready -> one request per pop resumes.
- 3 requests outstanding, 3-cycle memory latency, redirect_pc=0x1003: 3 stale responses discarded, next request addr 0x1000, first decode pc 0x1000.
- Redirect same cycle as a response and an if_valid&&if_ready: no pop counted, response dropped, FIFO empty next cycle, imem_req_valid low in redirect cycle.
- Redirect_pc=64'hFFFF_FFFF_FFFF_FFFC, sequential fetch: addresses ...FFFC then 0x0, if_pc follows.
- FETCH_PERF_EN defined, 10 instructions consumed with 3 starved if_ready cycles: perf_fetched=10, perf_stall=3; async rst mid-run -> both 0 immediately.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction-memory request/response, redirect, and decode hand-off.
// FETCH_PERF_EN adds the perf_fetched / perf_stall counter outputs.
interface instr_fetch_if #(
  parameter int XLEN = 64
);
  // Every valid/ready pair transfers on a rising edge where both are high; valid never
  // depends on ready, and payload is held while valid is high and ready is low.
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] pc_out;
`ifdef FETCH_PERF_EN
  logic [63:0]     perf_fetched;
  logic [63:0]     perf_stall;
`endif

  modport master (
`ifdef FETCH_PERF_EN
    output perf_fetched, output perf_stall,
`endif
    output imem_req_valid, input imem_req_ready, output imem_req_addr,
    input imem_rsp_valid, input imem_rsp_data,
    input redirect_valid, input redirect_pc,
    output if_valid, input if_ready, output if_instr, output if_pc,
    output pc_out
  );

  modport slave (
`ifdef FETCH_PERF_EN
    input perf_fetched, input perf_stall,
`endif
    input imem_req_valid, output imem_req_ready, input imem_req_addr,
    output imem_rsp_valid, output imem_rsp_data,
    output redirect_valid, output redirect_pc,
    input if_valid, output if_ready, input if_instr, input if_pc,
    input pc_out
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch with credit-limited requests, a registered prefetch FIFO
// and redirect flush. Optional perf counters behind the FETCH_PERF_EN macro.
module instr_fetch_unit #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4,
  parameter int              ADDR_STEP  = 4
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t          fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [XLEN-1:0]  target, step;
  logic [CNT_W:0]   inflight;
  logic             req_fire, rsp_fire, push, pop;

  assign step   = XLEN'(ADDR_STEP);
  assign target = bus.redirect_pc & ~XLEN'(3);

  // Requests in flight plus buffered entries never exceed the FIFO size, so no overflow.
  assign inflight           = {1'b0, outst_q} + {1'b0, count_q};
  assign bus.imem_req_valid = !rst && !bus.redirect_valid &&
                              (inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.pc_out         = fetch_pc_q;
  assign bus.if_valid       = (count_q != '0);
  assign bus.if_instr       = fifo_q[rd_ptr_q].instr;
  assign bus.if_pc          = fifo_q[rd_ptr_q].pc;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_fire = bus.imem_rsp_valid && (outst_q != '0);
  assign pop      = bus.if_valid && bus.if_ready && !bus.redirect_valid;
  assign push     = rsp_fire && (drop_q == '0) && !bus.redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (bus.redirect_valid) begin
      // Everything still outstanding after this cycle's response belongs to the old path.
      fetch_pc_d = target;
      resp_pc_d  = target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      outst_d    = outst_q - CNT_W'(rsp_fire);
      drop_d     = outst_q - CNT_W'(rsp_fire);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + step;
      outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + step;
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Entries reset so the decode-side outputs read {RESET_PC, 0} out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '{pc: RESET_PC, instr: 32'h0};
    end else if (push) begin
      fifo_q[wr_ptr_q] <= '{pc: resp_pc_q, instr: bus.imem_rsp_data};
    end
  end

`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop) perf_fetched_q <= perf_fetched_q + 64'd1;
      if (bus.if_ready && !bus.if_valid) perf_stall_q <= perf_stall_q + 64'd1;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: in-order memory model with random latency, decode-stream
// reference (sequential PCs from the last redirect target) and credit/occupancy model.
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  instr_fetch_if bus ();

  instr_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // memory model and reference state
  int          cyc = 0;
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  int          mq_ep[$];
  int          last_due, epoch, cur_ep, fifo_cnt, lat_min, lat_max;
  int          cred_err, vld_err;
  longint unsigned exp_fetched, exp_stall;
  logic [63:0] obs_req[$];
  logic [63:0] obs_pc[$];
  logic [31:0] obs_in[$];

  task automatic clear_obs();
    obs_req.delete();
    obs_pc.delete();
    obs_in.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.if_ready       = 1'b0;
    mq_addr.delete(); mq_due.delete(); mq_ep.delete();
    fifo_cnt = 0; cur_ep = 0; epoch = 0;
    cred_err = 0; vld_err = 0; exp_fetched = 0; exp_stall = 0;
    lat_min = 1; lat_max = 1;
    clear_obs();
    @(posedge clk); #1;
    rst = 1'b0;
    last_due = cyc;
  endtask

  // One clock: observe at the falling edge, advance the models, drive memory after the edge.
  task automatic tick();
    logic exp_rv, req_f, dec_f;
    int   outst, d;
    @(negedge clk);
    outst  = mq_addr.size() + (bus.imem_rsp_valid ? 1 : 0);
    exp_rv = !bus.redirect_valid && (outst + fifo_cnt < DEPTH);
    if (bus.imem_req_valid !== exp_rv) cred_err++;
    if (bus.if_valid !== (fifo_cnt > 0)) vld_err++;
    req_f = bus.imem_req_valid && bus.imem_req_ready;
    dec_f = bus.if_valid && bus.if_ready && !bus.redirect_valid;
    if (bus.if_ready && fifo_cnt == 0) exp_stall++;
    if (dec_f) begin
      exp_fetched++;
      obs_pc.push_back(bus.if_pc);
      obs_in.push_back(bus.if_instr);
    end
    if (req_f) begin
      obs_req.push_back(bus.imem_req_addr);
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq_addr.push_back(bus.imem_req_addr);
      mq_due.push_back(d);
      mq_ep.push_back(epoch);
    end
    if (bus.redirect_valid) begin
      epoch++;
      fifo_cnt = 0;
    end else begin
      if (bus.imem_rsp_valid && cur_ep == epoch) fifo_cnt++;
      if (dec_f) fifo_cnt--;
    end
    @(posedge clk); cyc++; #1;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'(mq_addr[0] >> 2);
      cur_ep = mq_ep[0];
      void'(mq_addr.pop_front()); void'(mq_due.pop_front()); void'(mq_ep.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.if_ready       = 1'b1;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", bus.imem_req_valid); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%b exp=0", bus.if_valid); end
    checks++; if (bus.if_instr !== 32'h0) begin failures++; $display("FAIL reset_if_instr got=%h exp=0", bus.if_instr); end
    checks++; if (bus.if_pc !== 64'h0) begin failures++; $display("FAIL reset_if_pc got=%h exp=0", bus.if_pc); end
    checks++; if (bus.pc_out !== 64'h0) begin failures++; $display("FAIL reset_pc_out got=%h exp=0", bus.pc_out); end
`ifdef FETCH_PERF_EN
    checks++; if (bus.perf_fetched !== 64'h0 || bus.perf_stall !== 64'h0) begin failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", bus.perf_fetched, bus.perf_stall); end
`endif
    do_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_req[i] !== 64'(4 * i)) begin failures++; $display("FAIL seq_req_addr[%0d] got=%h exp=%h", i, obs_req[i], 64'(4 * i)); end
      checks++; if (obs_pc[i] !== 64'(4 * i)) begin failures++; $display("FAIL seq_if_pc[%0d] got=%h exp=%h", i, obs_pc[i], 64'(4 * i)); end
      checks++; if (obs_in[i] !== 32'(i)) begin failures++; $display("FAIL seq_if_instr[%0d] got=%h exp=%h", i, obs_in[i], 32'(i)); end
    end
    checks++; if (bus.pc_out !== 64'(4 * obs_req.size())) begin failures++; $display("FAIL seq_pc_out got=%h exp=%h", bus.pc_out, 64'(4 * obs_req.size())); end
    checks++; if (cred_err != 0 || vld_err != 0) begin failures++; $display("FAIL seq_credit got=%0d/%0d exp=0/0", cred_err, vld_err); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b0;
    repeat (10) tick();
    checks++; if (obs_req.size() != DEPTH) begin failures++; $display("FAIL bp_req_count got=%0d exp=%0d", obs_req.size(), DEPTH); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%b exp=0", bus.imem_req_valid); end
    checks++; if (bus.if_pc !== 64'h0 || bus.if_valid !== 1'b1) begin failures++; $display("FAIL bp_head got=%h/%b exp=0/1", bus.if_pc, bus.if_valid); end
    bus.if_ready = 1'b1;
    tick();
    bus.if_ready = 1'b0;
    repeat (4) tick();
    checks++; if (obs_req.size() != DEPTH + 1) begin failures++; $display("FAIL bp_resume_count got=%0d exp=%0d", obs_req.size(), DEPTH + 1); end
    checks++; if (bus.if_pc !== 64'h4) begin failures++; $display("FAIL bp_head_after_pop got=%h exp=4", bus.if_pc); end
    checks++; if (cred_err != 0 || vld_err != 0) begin failures++; $display("FAIL bp_credit got=%0d/%0d exp=0/0", cred_err, vld_err); end
  endtask

  task automatic test_redirect_stale();
    do_reset();
    lat_min = 3; lat_max = 3;
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b1;
    repeat (3) tick();
    checks++; if (obs_req.size() != 3 || obs_pc.size() != 0) begin failures++; $display("FAIL stale_setup got=%0d/%0d exp=3/0", obs_req.size(), obs_pc.size()); end
    redirect_to(64'h1003);
    checks++; if (bus.pc_out !== 64'h1000) begin failures++; $display("FAIL stale_pc_out got=%h exp=1000", bus.pc_out); end
    clear_obs();
    repeat (15) tick();
    checks++; if (obs_req[0] !== 64'h1000) begin failures++; $display("FAIL stale_first_req got=%h exp=1000", obs_req[0]); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (obs_pc[i] !== 64'h1000 + 64'(4 * i)) begin failures++; $display("FAIL stale_if_pc[%0d] got=%h exp=%h", i, obs_pc[i], 64'h1000 + 64'(4 * i)); end
    end
    checks++; if (obs_in[0] !== 32'h400) begin failures++; $display("FAIL stale_if_instr got=%h exp=400", obs_in[0]); end
    checks++; if (cred_err != 0 || vld_err != 0) begin failures++; $display("FAIL stale_credit got=%0d/%0d exp=0/0", cred_err, vld_err); end
  endtask

  task automatic test_redirect_collision();
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b0;
    repeat (3) tick();
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h2000;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL coll_req_valid got=%b exp=0", bus.imem_req_valid); end
    checks++; if (bus.if_valid !== 1'b1 || bus.imem_rsp_valid !== 1'b1) begin failures++; $display("FAIL coll_setup got=%b/%b exp=1/1", bus.if_valid, bus.imem_rsp_valid); end
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL coll_flush got=%b exp=0", bus.if_valid); end
`ifdef FETCH_PERF_EN
    checks++; if (bus.perf_fetched !== 64'h0) begin failures++; $display("FAIL coll_no_pop got=%0d exp=0", bus.perf_fetched); end
`endif
    repeat (6) tick();
    checks++; if (obs_pc.size() == 0 || obs_pc[0] !== 64'h2000) begin failures++; $display("FAIL coll_first_pc got=%h exp=2000", (obs_pc.size() > 0) ? obs_pc[0] : 64'hx); end
    checks++; if (cred_err != 0 || vld_err != 0) begin failures++; $display("FAIL coll_credit got=%0d/%0d exp=0/0", cred_err, vld_err); end
  endtask

  task automatic test_wrap();
    do_reset();
    lat_min = 1; lat_max = 2;
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b1;
    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    clear_obs();
    repeat (10) tick();
    checks++; if (obs_req[0] !== 64'hFFFF_FFFF_FFFF_FFFC || obs_req[1] !== 64'h0) begin failures++; $display("FAIL wrap_req got=%h,%h exp=fffffffffffffffc,0", obs_req[0], obs_req[1]); end
    checks++; if (obs_pc[0] !== 64'hFFFF_FFFF_FFFF_FFFC || obs_pc[1] !== 64'h0) begin failures++; $display("FAIL wrap_if_pc got=%h,%h exp=fffffffffffffffc,0", obs_pc[0], obs_pc[1]); end
    checks++; if (obs_in[0] !== 32'hFFFF_FFFF || obs_in[1] !== 32'h0) begin failures++; $display("FAIL wrap_if_instr got=%h,%h exp=ffffffff,0", obs_in[0], obs_in[1]); end
  endtask

  task automatic test_random();
    logic [63:0] exp_req, exp_dec, tgt;
    do_reset();
    lat_min = 1; lat_max = 4;
    exp_req = 64'h0;
    exp_dec = 64'h0;
    for (int n = 0; n < 2000; n++) begin
      bus.imem_req_ready = ($urandom_range(3, 0) != 0);
      bus.if_ready       = ($urandom_range(9, 0) < 7);
      if ($urandom_range(99, 0) < 3) begin
        tgt = {$urandom, $urandom};
        if ($urandom_range(1, 0) == 1) tgt[63:16] = '1;
        redirect_to(tgt);
        exp_req = tgt & ~64'h3;
        exp_dec = tgt & ~64'h3;
      end else begin
        tick();
      end
      while (obs_req.size() > 0) begin
        checks++; if (obs_req[0] !== exp_req) begin failures++; $display("FAIL rnd_req_addr got=%h exp=%h", obs_req[0], exp_req); end
        void'(obs_req.pop_front());
        exp_req = exp_req + 64'd4;
      end
      while (obs_pc.size() > 0) begin
        checks++; if (obs_pc[0] !== exp_dec || obs_in[0] !== 32'(exp_dec >> 2)) begin failures++; $display("FAIL rnd_decode got=%h:%h exp=%h:%h", obs_pc[0], obs_in[0], exp_dec, 32'(exp_dec >> 2)); end
        void'(obs_pc.pop_front());
        void'(obs_in.pop_front());
        exp_dec = exp_dec + 64'd4;
      end
      checks++; if (bus.pc_out !== exp_req) begin failures++; $display("FAIL rnd_pc_out got=%h exp=%h", bus.pc_out, exp_req); end
    end
    checks++; if (cred_err != 0) begin failures++; $display("FAIL rnd_credit got=%0d exp=0", cred_err); end
    checks++; if (vld_err != 0) begin failures++; $display("FAIL rnd_if_valid got=%0d exp=0", vld_err); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int guard;
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b1;
    guard = 0;
    while (exp_fetched < 10 && guard < 100) begin
      bus.if_ready = (guard == 6) ? 1'b0 : 1'b1;
      tick();
      guard++;
    end
    bus.if_ready = 1'b0;
    checks++; if (exp_fetched != 10) begin failures++; $display("FAIL perf_pops got=%0d exp=10", exp_fetched); end
    checks++; if (bus.perf_fetched !== 64'(exp_fetched)) begin failures++; $display("FAIL perf_fetched got=%0d exp=%0d", bus.perf_fetched, exp_fetched); end
    checks++; if (bus.perf_stall !== 64'(exp_stall)) begin failures++; $display("FAIL perf_stall got=%0d exp=%0d", bus.perf_stall, exp_stall); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.perf_fetched !== 64'h0 || bus.perf_stall !== 64'h0) begin failures++; $display("FAIL perf_async_rst got=%0d/%0d exp=0/0", bus.perf_fetched, bus.perf_stall); end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_stale();
    test_redirect_collision();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
